// File: rtl/mcdt_pkg.sv
// Shared parameters, types and the round-robin pick function for the
// multi-channel data transfer block.
package mcdt_pkg;

  localparam int DATA_W     = 32;
  localparam int FIFO_DEPTH = 32;
  localparam int MARGIN_W   = 6;
  localparam int CH_NUM     = 3;

  typedef logic [DATA_W-1:0]   data_t;
  typedef logic [1:0]          chid_t;
  typedef logic [MARGIN_W-1:0] margin_t;

  // One-hot grant: the first requester at or after last+1, wrapping at CH_NUM.
  function automatic logic [CH_NUM-1:0] rr_pick(input chid_t last,
                                                input logic [CH_NUM-1:0] req);
    logic [CH_NUM-1:0] gnt;
    chid_t             idx;
    gnt = '0;
    idx = (last >= chid_t'(CH_NUM-1)) ? chid_t'(0) : chid_t'(last + 2'd1);
    for (int i = 0; i < CH_NUM; i++) begin
      if (gnt == '0 && req[idx]) begin
        gnt[idx] = 1'b1;
      end
      idx = (idx == chid_t'(CH_NUM-1)) ? chid_t'(0) : chid_t'(idx + 2'd1);
    end
    return gnt;
  endfunction

  function automatic chid_t onehot_to_id(input logic [CH_NUM-1:0] gnt);
    chid_t id;
    id = 2'd0;
    if (gnt[1]) id = 2'd1;
    if (gnt[2]) id = 2'd2;
    return id;
  endfunction

endpackage

// File: rtl/mcdt_if.sv
// Producer-side channels and the merged output stream of mcdt.
interface mcdt_if;
  import mcdt_pkg::*;

  data_t   ch0_data_i;
  logic    ch0_valid_i;
  logic    ch0_ready_o;
  margin_t ch0_margin_o;

  data_t   ch1_data_i;
  logic    ch1_valid_i;
  logic    ch1_ready_o;
  margin_t ch1_margin_o;

  data_t   ch2_data_i;
  logic    ch2_valid_i;
  logic    ch2_ready_o;
  margin_t ch2_margin_o;

  data_t   mcdt_data_o;
  logic    mcdt_val_o;
  chid_t   mcdt_id_o;

  modport master (
    output ch0_data_i, ch0_valid_i, ch1_data_i, ch1_valid_i, ch2_data_i, ch2_valid_i,
    input  ch0_ready_o, ch0_margin_o, ch1_ready_o, ch1_margin_o, ch2_ready_o, ch2_margin_o,
    input  mcdt_data_o, mcdt_val_o, mcdt_id_o
  );

  modport slave (
    input  ch0_data_i, ch0_valid_i, ch1_data_i, ch1_valid_i, ch2_data_i, ch2_valid_i,
    output ch0_ready_o, ch0_margin_o, ch1_ready_o, ch1_margin_o, ch2_ready_o, ch2_margin_o,
    output mcdt_data_o, mcdt_val_o, mcdt_id_o
  );

endinterface

// File: rtl/mcdt_chnl_fifo.sv
// Per-channel synchronous FIFO with a free-slot margin output.
module mcdt_chnl_fifo
  import mcdt_pkg::*;
(
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    push,
  input  data_t   push_data,
  input  logic    pop,
  output data_t   head_data,
  output logic    empty,
  output logic    full,
  output margin_t margin
);

  localparam int      PTR_W = $clog2(FIFO_DEPTH);
  localparam margin_t DEPTH = margin_t'(FIFO_DEPTH);

  data_t            mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  margin_t          count;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count == '0);
  assign full      = (count == DEPTH);
  assign margin    = DEPTH - count;
  assign head_data = mem[rd_ptr];
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;

  // Storage carries no reset; the pointers and count alone define validity.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mcdt.sv
// Three buffered write channels merged round-robin onto one tagged output.
module mcdt
  import mcdt_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  mcdt_if.slave bus
);

  data_t             ch_data [CH_NUM];
  data_t             head    [CH_NUM];
  margin_t           margin  [CH_NUM];
  logic [CH_NUM-1:0] ch_valid;
  logic [CH_NUM-1:0] ch_push;
  logic [CH_NUM-1:0] fifo_empty;
  logic [CH_NUM-1:0] fifo_full;
  logic [CH_NUM-1:0] gnt;
  chid_t             gnt_id;
  chid_t             last_grant;
  data_t             out_data;
  logic              out_val;
  chid_t             out_id;

  assign ch_data[0] = bus.ch0_data_i;
  assign ch_data[1] = bus.ch1_data_i;
  assign ch_data[2] = bus.ch2_data_i;
  assign ch_valid   = {bus.ch2_valid_i, bus.ch1_valid_i, bus.ch0_valid_i};

  // Acceptance uses the pre-edge full flag, so a full FIFO refuses even when popped.
  assign ch_push = ch_valid & ~fifo_full;

  for (genvar i = 0; i < CH_NUM; i++) begin : g_fifo
    mcdt_chnl_fifo u_fifo (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .push      (ch_push[i]),
      .push_data (ch_data[i]),
      .pop       (gnt[i]),
      .head_data (head[i]),
      .empty     (fifo_empty[i]),
      .full      (fifo_full[i]),
      .margin    (margin[i])
    );
  end

  assign gnt    = rr_pick(last_grant, ~fifo_empty);
  assign gnt_id = onehot_to_id(gnt);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_grant <= 2'd2;
      out_val    <= 1'b0;
      out_data   <= '0;
      out_id     <= '0;
    end else if (|gnt) begin
      last_grant <= gnt_id;
      out_val    <= 1'b1;
      out_data   <= head[gnt_id];
      out_id     <= gnt_id;
    end else begin
      out_val    <= 1'b0;
      out_data   <= '0;
      out_id     <= '0;
    end
  end

  assign bus.mcdt_data_o  = out_data;
  assign bus.mcdt_val_o   = out_val;
  assign bus.mcdt_id_o    = out_id;
  assign bus.ch0_ready_o  = ~fifo_full[0];
  assign bus.ch1_ready_o  = ~fifo_full[1];
  assign bus.ch2_ready_o  = ~fifo_full[2];
  assign bus.ch0_margin_o = margin[0];
  assign bus.ch1_margin_o = margin[1];
  assign bus.ch2_margin_o = margin[2];

endmodule

// File: tb/tb_mcdt.sv
// Directed bench for mcdt: reset, single channels, round robin, full FIFOs,
// drain and reset mid-stream.
module tb_mcdt;
  import mcdt_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  data_t base [3] = '{32'h00C0_1000, 32'h00C1_1000, 32'h00C2_1000};
  int    pushed [3] = '{0, 0, 0};
  int    popped [3] = '{0, 0, 0};
  logic  accept [3];
  logic  seen_full [3] = '{1'b0, 1'b0, 1'b0};
  int    exp_id;
  int    got_id;

  mcdt_if bus();

  mcdt dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int c, input logic v, input data_t d);
    case (c)
      0:       begin bus.ch0_valid_i = v; bus.ch0_data_i = d; end
      1:       begin bus.ch1_valid_i = v; bus.ch1_data_i = d; end
      default: begin bus.ch2_valid_i = v; bus.ch2_data_i = d; end
    endcase
  endtask

  function automatic margin_t marginOf(input int c);
    case (c)
      0:       return bus.ch0_margin_o;
      1:       return bus.ch1_margin_o;
      default: return bus.ch2_margin_o;
    endcase
  endfunction

  function automatic logic readyOf(input int c);
    case (c)
      0:       return bus.ch0_ready_o;
      1:       return bus.ch1_ready_o;
      default: return bus.ch2_ready_o;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("[TB] check %s", tag);
    end
  endtask

  initial begin
    for (int c = 0; c < 3; c++) applyStimulus(c, 1'b0, '0);

    // Reset held for ten edges
    rst = 1'b1;
    repeat (10) tick();
    for (int c = 0; c < 3; c++) begin
      checkOutput($sformatf("reset_ready%0d", c), 32'(readyOf(c)), 32'd1);
      checkOutput($sformatf("reset_margin%0d", c), 32'(marginOf(c)), 32'd32);
    end
    checkOutput("reset_val", 32'(bus.mcdt_val_o), 32'd0);
    checkOutput("reset_data", bus.mcdt_data_o, 32'd0);
    checkOutput("reset_id", 32'(bus.mcdt_id_o), 32'd0);
    rst = 1'b0;

    // One channel at a time, a one-cycle pulse every two cycles
    for (int c = 0; c < 3; c++) begin
      for (int k = 0; k < 10; k++) begin
        applyStimulus(c, 1'b1, 32'h00C0_0000 + 32'(c) * 32'h0001_0000 + 32'(k));
        tick();
        applyStimulus(c, 1'b0, '0);
        checkOutput($sformatf("single%0d_idle_val_%0d", c, k), 32'(bus.mcdt_val_o), 32'd0);
        checkOutput($sformatf("single%0d_margin_in_%0d", c, k), 32'(marginOf(c)), 32'd31);
        tick();
        checkOutput($sformatf("single%0d_val_%0d", c, k), 32'(bus.mcdt_val_o), 32'd1);
        checkOutput($sformatf("single%0d_id_%0d", c, k), 32'(bus.mcdt_id_o), 32'(c));
        checkOutput($sformatf("single%0d_data_%0d", c, k), bus.mcdt_data_o,
                    32'h00C0_0000 + 32'(c) * 32'h0001_0000 + 32'(k));
        checkOutput($sformatf("single%0d_margin_out_%0d", c, k), 32'(marginOf(c)), 32'd32);
      end
    end

    // All channels every cycle; junk is offered whenever a channel is not ready
    for (int j = 0; j < 60; j++) begin
      for (int c = 0; c < 3; c++) begin
        accept[c] = readyOf(c);
        applyStimulus(c, 1'b1, accept[c] ? base[c] + 32'(pushed[c]) : 32'hDEAD_0000 + 32'(c));
      end
      tick();
      for (int c = 0; c < 3; c++) if (accept[c]) pushed[c]++;
      if (j == 0) begin
        checkOutput("rr_first_val", 32'(bus.mcdt_val_o), 32'd0);
        for (int c = 0; c < 3; c++)
          checkOutput($sformatf("rr_first_margin%0d", c), 32'(marginOf(c)), 32'd31);
      end else begin
        exp_id = (j - 1) % 3;
        checkOutput($sformatf("rr_val_%0d", j), 32'(bus.mcdt_val_o), 32'd1);
        checkOutput($sformatf("rr_id_%0d", j), 32'(bus.mcdt_id_o), 32'(exp_id));
        checkOutput($sformatf("rr_data_%0d", j), bus.mcdt_data_o, base[exp_id] + 32'(popped[exp_id]));
        popped[exp_id]++;
      end
      if (j == 46) begin
        checkOutput("full_margin1_e46", 32'(marginOf(1)), 32'd0);
        checkOutput("full_margin2_e46", 32'(marginOf(2)), 32'd0);
        checkOutput("full_ready2_e46", 32'(readyOf(2)), 32'd0);
        checkOutput("notfull_margin0_e46", 32'(marginOf(0)), 32'd1);
      end
      if (j == 47) begin
        checkOutput("full_margin0_e47", 32'(marginOf(0)), 32'd0);
        checkOutput("full_ready0_e47", 32'(readyOf(0)), 32'd0);
      end
      for (int c = 0; c < 3; c++)
        if (marginOf(c) == '0 && !readyOf(c)) seen_full[c] = 1'b1;
    end
    for (int c = 0; c < 3; c++)
      checkOutput($sformatf("seen_full%0d", c), 32'(seen_full[c]), 32'd1);

    // Drain with no new writes
    for (int c = 0; c < 3; c++) applyStimulus(c, 1'b0, '0);
    for (int d = 0; d < 120; d++) begin
      tick();
      if (bus.mcdt_val_o === 1'b1) begin
        got_id = int'(bus.mcdt_id_o);
        checkOutput($sformatf("drain_id_range_%0d", d), 32'(got_id < 3), 32'd1);
        if (got_id < 3) begin
          checkOutput($sformatf("drain_data_%0d", d), bus.mcdt_data_o, base[got_id] + 32'(popped[got_id]));
          popped[got_id]++;
        end
      end
    end
    for (int c = 0; c < 3; c++) begin
      checkOutput($sformatf("drain_count%0d", c), 32'(popped[c]), 32'(pushed[c]));
      checkOutput($sformatf("drain_margin%0d", c), 32'(marginOf(c)), 32'd32);
    end
    checkOutput("drain_val", 32'(bus.mcdt_val_o), 32'd0);

    // Leave the arbiter pointer on channel 0 before the mid-stream reset
    applyStimulus(0, 1'b1, 32'h00C0_2000);
    tick();
    applyStimulus(0, 1'b0, '0);
    tick();
    checkOutput("prime_id", 32'(bus.mcdt_id_o), 32'd0);
    checkOutput("prime_data", bus.mcdt_data_o, 32'h00C0_2000);

    for (int m = 0; m < 4; m++) begin
      for (int c = 0; c < 3; c++) applyStimulus(c, 1'b1, 32'h0BAD_0000 + 32'(c * 16 + m));
      tick();
      if (m > 0) checkOutput($sformatf("mid_id_%0d", m), 32'(bus.mcdt_id_o), 32'(m % 3));
    end

    for (int c = 0; c < 3; c++) applyStimulus(c, 1'b0, '0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midrst_val", 32'(bus.mcdt_val_o), 32'd0);
    checkOutput("midrst_data", bus.mcdt_data_o, 32'd0);
    checkOutput("midrst_id", 32'(bus.mcdt_id_o), 32'd0);
    for (int c = 0; c < 3; c++) begin
      checkOutput($sformatf("midrst_margin%0d", c), 32'(marginOf(c)), 32'd32);
      checkOutput($sformatf("midrst_ready%0d", c), 32'(readyOf(c)), 32'd1);
    end

    // After reset channel 0 has first priority and nothing stale comes out
    for (int c = 0; c < 3; c++) applyStimulus(c, 1'b1, 32'h00C0_4000 + 32'(c));
    tick();
    for (int c = 0; c < 3; c++) applyStimulus(c, 1'b0, '0);
    checkOutput("post_push_val", 32'(bus.mcdt_val_o), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput($sformatf("post_val_%0d", k), 32'(bus.mcdt_val_o), 32'd1);
      checkOutput($sformatf("post_id_%0d", k), 32'(bus.mcdt_id_o), 32'(k));
      checkOutput($sformatf("post_data_%0d", k), bus.mcdt_data_o, 32'h00C0_4000 + 32'(k));
    end
    for (int k = 0; k < 8; k++) begin
      tick();
      checkOutput($sformatf("post_idle_val_%0d", k), 32'(bus.mcdt_val_o), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
